// File: rtl/puf_response_sampler.sv
// Temporal majority-vote sampler between the PUF array and the BCH stage.
// Optional PUF_STABILITY_MASK_EN adds per-bit unstable flags and their popcount.
module puf_response_sampler #(
    parameter int RESP_W = 48,
    parameter int VOTES  = 5,
    localparam int CNT_W = $clog2(VOTES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              puf_req,
    input  logic              puf_ack,
    input  logic [RESP_W-1:0] puf_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_data,
`ifdef PUF_STABILITY_MASK_EN
    output logic [RESP_W-1:0]           unstable_mask,
    output logic [$clog2(RESP_W+1)-1:0] unstable_cnt,
`endif
    output logic              busy
);

    if ((VOTES < 1) || ((VOTES % 2) == 0)) begin : g_bad_votes
        $error("puf_response_sampler: VOTES must be odd and >= 1");
    end

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_VOTE = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] cnt [RESP_W];
    logic [RESP_W-1:0] vote_bits;

    function automatic logic majority(input logic [CNT_W-1:0] c);
        return c > CNT_W'(VOTES / 2);
    endfunction

    assign puf_req = (state == S_REQ);
    assign busy    = (state != S_IDLE);

    always_comb begin
        vote_bits = '0;
        for (int i = 0; i < RESP_W; i++) begin
            vote_bits[i] = majority(cnt[i]);
        end
    end

    // Sample accept / vote / handshake sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            scnt       <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            for (int i = 0; i < RESP_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_REQ;
                        scnt  <= '0;
                        for (int i = 0; i < RESP_W; i++) begin
                            cnt[i] <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (puf_ack) begin
                        for (int i = 0; i < RESP_W; i++) begin
                            cnt[i] <= cnt[i] + CNT_W'(puf_data[i]);
                        end
                        scnt  <= scnt + CNT_W'(1);
                        state <= (scnt < CNT_W'(VOTES - 1)) ? S_GAP : S_VOTE;
                    end
                end
                S_GAP: begin
                    state <= S_REQ;
                end
                S_VOTE: begin
                    resp_data <= vote_bits;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    // Data settles on entry; valid follows one cycle later and holds until taken.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PUF_STABILITY_MASK_EN
    localparam int UC_W = $clog2(RESP_W + 1);

    logic [RESP_W-1:0] unstable_bits;

    function automatic logic non_unanimous(input logic [CNT_W-1:0] c);
        return (c != '0) && (c != CNT_W'(VOTES));
    endfunction

    function automatic logic [UC_W-1:0] popcount(input logic [RESP_W-1:0] v);
        logic [UC_W-1:0] n;
        n = '0;
        for (int i = 0; i < RESP_W; i++) begin
            n = n + UC_W'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        unstable_bits = '0;
        for (int i = 0; i < RESP_W; i++) begin
            unstable_bits[i] = non_unanimous(cnt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unstable_mask <= '0;
            unstable_cnt  <= '0;
        end else if (state == S_VOTE) begin
            unstable_mask <= unstable_bits;
            unstable_cnt  <= popcount(unstable_bits);
        end
    end
`endif

endmodule

// File: tb/tb_puf_response_sampler.sv
// Bench for puf_response_sampler: vector table driven through a PUF responder,
// expected responses queued at start and checked at the output handshake.
module tb_puf_response_sampler;

    localparam int RW = 48;
    localparam int NV = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          puf_req;
    logic          puf_ack;
    logic [RW-1:0] puf_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [RW-1:0] resp_data;
    logic          busy;
`ifdef PUF_STABILITY_MASK_EN
    logic [RW-1:0] um;
    logic [5:0]    uc;
`endif

    puf_response_sampler #(.RESP_W(RW), .VOTES(NV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .puf_req    (puf_req),
        .puf_ack    (puf_ack),
        .puf_data   (puf_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
`ifdef PUF_STABILITY_MASK_EN
        .unstable_mask (um),
        .unstable_cnt  (uc),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV-1:0][RW-1:0] samp;
        int                    ack_delay;
        int                    ready_delay;
        bit                    spurious;
        int                    restart_k;
        logic [RW-1:0]         exp_data;
        logic [RW-1:0]         exp_mask;
    } vec_t;

    typedef struct {
        logic [RW-1:0] data;
        logic [RW-1:0] mask;
        int            ucnt;
    } exp_t;

    vec_t vecs [6];
    exp_t sbq [$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e, got;
        int   k, lat, idx, w, nrise, ek;
        logic prev_req, prev_acc, stable, hs, done, quiet;
        logic [RW-1:0] held;
        e.data = v.exp_data;
        e.mask = v.exp_mask;
        e.ucnt = $countones(v.exp_mask);
        sbq.push_back(e);
        ek = 2 * NV + 1 + NV * v.ack_delay;
        @(negedge clk);
        start      = 1'b1;
        resp_ready = (v.ready_delay == 0);
        @(posedge clk);
        k = 0; idx = 0; w = 0; nrise = 0; lat = -1;
        prev_req = 1'b0; prev_acc = 1'b0; stable = 1'b1; hs = 1'b0; done = 1'b0;
        held = '0;
        while (!done && k < 300) begin
            @(negedge clk);
            if (hs) begin
                chk({tag, "_idle_valid"}, 64'(resp_valid), 64'd0);
                chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
                chk({tag, "_idle_data_held"}, 64'(resp_data), 64'(e.data));
                chk({tag, "_latency"}, 64'(lat), 64'(ek));
                chk({tag, "_req_edges"}, 64'(nrise), 64'(NV));
                chk({tag, "_stable"}, 64'(stable), 64'd1);
                resp_ready = 1'b0;
                puf_ack    = 1'b0;
                done       = 1'b1;
            end else begin
                start = (k == v.restart_k);
                if (prev_acc) begin
                    idx++;
                    w = 0;
                end
                if (puf_req && !prev_req) nrise++;
                prev_req = puf_req;
                if (resp_valid) begin
                    if (lat < 0) begin
                        lat  = k;
                        held = resp_data;
                    end else if (resp_data !== held) begin
                        stable = 1'b0;
                    end
                end
                resp_ready = (v.ready_delay == 0) || (lat >= 0 && (k - lat) >= v.ready_delay);
                if (resp_valid && resp_ready) begin
                    hs = 1'b1;
                    if (sbq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL %s_sb_empty: response with no expectation queued", tag);
                    end else begin
                        got = sbq.pop_front();
                        chk({tag, "_data"}, 64'(resp_data), 64'(got.data));
`ifdef PUF_STABILITY_MASK_EN
                        chk({tag, "_mask"}, 64'(um), 64'(got.mask));
                        chk({tag, "_ucnt"}, 64'(uc), 64'(got.ucnt));
`endif
                    end
                end
                if (puf_req) begin
                    if (w < v.ack_delay) begin
                        puf_ack = 1'b0;
                        w++;
                    end else begin
                        puf_ack  = 1'b1;
                        puf_data = v.samp[(idx < NV) ? idx : NV - 1];
                    end
                end else if (v.spurious) begin
                    puf_ack  = 1'b1;
                    puf_data = ~v.samp[(idx < NV) ? idx : NV - 1];
                end else begin
                    puf_ack = 1'b0;
                end
                prev_acc = puf_req && puf_ack;
                k++;
            end
        end
        start = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no handshake after %0d cycles, required within 300", tag, k);
            return;
        end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid || busy) quiet = 1'b0;
        end
        chk({tag, "_no_extra_resp"}, 64'(quiet), 64'd1);
    endtask

    initial begin
        logic [RW-1:0] c;
        int   idx, k;
        logic prev_acc, reached, quiet;
        vec_t fresh;

        c = 48'h1234_5678_9ABC;
        for (int i = 0; i < 6; i++) begin
            vecs[i].ack_delay = 0; vecs[i].ready_delay = 0;
            vecs[i].spurious = 1'b0; vecs[i].restart_k = -1;
        end
        for (int s = 0; s < NV; s++) vecs[0].samp[s] = 48'h012345;
        vecs[0].exp_data = 48'h012345; vecs[0].exp_mask = '0;

        vecs[1].samp[0] = 48'h012345; vecs[1].samp[1] = 48'h013346;
        vecs[1].samp[2] = 48'h012345; vecs[1].samp[3] = 48'h013346;
        vecs[1].samp[4] = 48'h012345;
        vecs[1].exp_data = 48'h012345; vecs[1].exp_mask = 48'h001003;

        vecs[2] = vecs[0];
        vecs[2].ack_delay = 3; vecs[2].spurious = 1'b1;

        for (int s = 0; s < NV; s++)
            vecs[3].samp[s] = (s == 1 || s == 3) ? 48'h0000_FFFF_5555 : 48'hFFFF_0000_AAAA;
        vecs[3].ready_delay = 10;
        vecs[3].exp_data = 48'hFFFF_0000_AAAA; vecs[3].exp_mask = 48'hFFFF_FFFF_FFFF;

        vecs[4].samp[0] = c; vecs[4].samp[1] = c; vecs[4].samp[2] = c;
        vecs[4].samp[3] = '0; vecs[4].samp[4] = '0;
        vecs[4].restart_k = 2;
        vecs[4].exp_data = c; vecs[4].exp_mask = c;

        for (int s = 0; s < NV; s++) vecs[5].samp[s] = '1;
        vecs[5].ack_delay = 1;
        vecs[5].exp_data = '1; vecs[5].exp_mask = '0;

        rst_n = 1'b0; start = 1'b0; puf_ack = 1'b0; puf_data = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_puf_req", 64'(puf_req), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_data", 64'(resp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while the third sample is being requested, after two all-ones samples.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        idx = 0; k = 0; prev_acc = 1'b0; reached = 1'b0;
        while (!reached && k < 100) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_acc) idx++;
            if (idx == 2 && puf_req) begin
                reached = 1'b1;
                puf_ack = 1'b0;
            end else begin
                puf_ack  = puf_req;
                puf_data = '1;
                prev_acc = puf_req;
            end
            k++;
        end
        chk("rst_mid_reached", 64'(reached), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_puf_req", 64'(puf_req), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid || busy) quiet = 1'b0;
        end
        chk("rst_mid_no_valid", 64'(quiet), 64'd1);

        fresh = vecs[0];
        fresh.samp[0] = c; fresh.samp[1] = c;
        fresh.samp[2] = '0; fresh.samp[3] = '0; fresh.samp[4] = '0;
        fresh.exp_data = '0; fresh.exp_mask = c;
        run_vec(fresh, "post_rst");

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
